// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package reg_wb_arbiter_pkg;

   localparam int REG_W            = 5;
   localparam int DATA_W           = 32;
   localparam int FIFO_DEPTH       = 2;
   localparam int CNT_W            = 2;
   localparam int AGE_W            = 4;
   localparam int DEFAULT_MAX_WAIT = 4;

   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } mc_entry_t;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_PIPE,
      GRANT_FIFO
   } grant_t;

   function automatic logic [REG_W-1:0] pipe_dest(input logic             r_type,
                                                   input logic [REG_W-1:0] rs2,
                                                   input logic [REG_W-1:0] rd);
      return r_type ? rd : rs2;
   endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of pipeline writeback, multicycle handshake and register-file write port.
interface reg_wb_arbiter_if;
   import reg_wb_arbiter_pkg::*;

   logic              wb_valid;
   logic              wb_r_type;
   logic [REG_W-1:0]  wb_rs2;
   logic [REG_W-1:0]  wb_rd;
   logic [DATA_W-1:0] wb_data;

   logic              mc_valid;
   logic              mc_ready;
   logic [REG_W-1:0]  mc_rd;
   logic [DATA_W-1:0] mc_data;

   logic              stall_pipe;
   logic              reg_wr;
   logic              r_type;
   logic [REG_W-1:0]  rs2_wb;
   logic [REG_W-1:0]  rd_wb;
   logic [DATA_W-1:0] busW;

   modport slave (
      input  wb_valid, wb_r_type, wb_rs2, wb_rd, wb_data,
      input  mc_valid, mc_rd, mc_data,
      output mc_ready, stall_pipe,
      output reg_wr, r_type, rs2_wb, rd_wb, busW
   );

   modport master (
      output wb_valid, wb_r_type, wb_rs2, wb_rd, wb_data,
      output mc_valid, mc_rd, mc_data,
      input  mc_ready, stall_pipe,
      input  reg_wr, r_type, rs2_wb, rd_wb, busW
   );

endinterface

// File: rtl/reg_wb_arbiter_fifo.sv
// Two-entry FIFO of multicycle results; head is visible combinationally.
module wb_fifo2
   import reg_wb_arbiter_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  mc_entry_t push_entry,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output mc_entry_t head
);

   mc_entry_t        mem_reg [FIFO_DEPTH];
   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_reg[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Storage carries no reset: validity is tracked solely by count_reg.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop_ok) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register-file write port between the pipeline writeback stage
// and buffered multicycle results, stalling the pipeline when a result ages out.
module reg_wb_arbiter
   import reg_wb_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic             clk,
   input  logic             reset,
   reg_wb_arbiter_if.slave  bus
);

   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   mc_entry_t         push_entry;
   mc_entry_t         head;
   grant_t            grant;
   logic              stall;
   logic [AGE_W-1:0]  age_reg;
   logic [AGE_W-1:0]  age_next;

   logic              reg_wr_reg,  reg_wr_next;
   logic              r_type_reg,  r_type_next;
   logic [REG_W-1:0]  rs2_wb_reg,  rs2_wb_next;
   logic [REG_W-1:0]  rd_wb_reg,   rd_wb_next;
   logic [DATA_W-1:0] busw_reg,    busw_next;
   logic [REG_W-1:0]  wb_dest;

   // Full blocks acceptance even when the head pops this cycle, keeping ready registered-only.
   assign bus.mc_ready = !fifo_full;
   assign push         = bus.mc_valid && !fifo_full && (bus.mc_rd != ZERO_REG);
   assign push_entry   = '{rd: bus.mc_rd, data: bus.mc_data};
   assign stall        = !fifo_empty && (age_reg == AGE_MAX);
   assign bus.stall_pipe = stall;
   assign pop          = (grant == GRANT_FIFO);
   assign wb_dest      = pipe_dest(bus.wb_r_type, bus.wb_rs2, bus.wb_rd);

   wb_fifo2 u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (head)
   );

   always_comb begin
      grant = GRANT_NONE;
      if (stall) begin
         grant = GRANT_FIFO;
      end else if (bus.wb_valid) begin
         grant = GRANT_PIPE;
      end else if (!fifo_empty) begin
         grant = GRANT_FIFO;
      end
   end

   // Age tracks how long the current head has been passed over.
   always_comb begin
      age_next = age_reg;
      if (pop || fifo_empty) begin
         age_next = '0;
      end else if (age_reg != AGE_MAX) begin
         age_next = age_reg + 1'b1;
      end
   end

   always_comb begin
      reg_wr_next = 1'b0;
      r_type_next = r_type_reg;
      rs2_wb_next = rs2_wb_reg;
      rd_wb_next  = rd_wb_reg;
      busw_next   = busw_reg;
      case (grant)
         GRANT_PIPE: begin
            reg_wr_next = (wb_dest != ZERO_REG);
            r_type_next = bus.wb_r_type;
            rs2_wb_next = bus.wb_rs2;
            rd_wb_next  = bus.wb_rd;
            busw_next   = bus.wb_data;
         end
         GRANT_FIFO: begin
            reg_wr_next = (head.rd != ZERO_REG);
            r_type_next = 1'b1;
            rs2_wb_next = ZERO_REG;
            rd_wb_next  = head.rd;
            busw_next   = head.data;
         end
         default: begin
            reg_wr_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         age_reg    <= '0;
         reg_wr_reg <= 1'b0;
         r_type_reg <= 1'b0;
         rs2_wb_reg <= '0;
         rd_wb_reg  <= '0;
         busw_reg   <= '0;
      end else begin
         age_reg    <= age_next;
         reg_wr_reg <= reg_wr_next;
         r_type_reg <= r_type_next;
         rs2_wb_reg <= rs2_wb_next;
         rd_wb_reg  <= rd_wb_next;
         busw_reg   <= busw_next;
      end
   end

   assign bus.reg_wr = reg_wr_reg;
   assign bus.r_type = r_type_reg;
   assign bus.rs2_wb = rs2_wb_reg;
   assign bus.rd_wb  = rd_wb_reg;
   assign bus.busW   = busw_reg;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed and randomized checks of reg_wb_arbiter against a queue-based reference model.
module tb_reg_wb_arbiter;
   import reg_wb_arbiter_pkg::*;

   localparam int MW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reg_wb_arbiter_if bus();

   reg_wb_arbiter #(.MAX_WAIT(MW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   int          m_age = 0;
   logic        e_reg_wr = 1'b0;
   logic        e_r_type = 1'b0;
   logic [4:0]  e_rs2 = '0;
   logic [4:0]  e_rd = '0;
   logic [31:0] e_busw = '0;
   int          n_assert = 0;
   int          n_fail = 0;
   logic        last_wb_acc = 1'b0;
   logic        last_mc_fire = 1'b0;
   logic [31:0] got_data[$];
   logic [4:0]  got_rd[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: compare handshake outputs, advance the model, compare write port.
   task automatic step();
      logic       m_stall, m_ready, fire, acc, take_fifo;
      logic [4:0] dest;
      ent_t       h;
      @(negedge clk);
      m_stall = (mq.size() > 0) && (m_age == MW);
      m_ready = (mq.size() < 2);
      check("stall_pipe", {31'd0, bus.stall_pipe}, {31'd0, m_stall});
      check("mc_ready", {31'd0, bus.mc_ready}, {31'd0, m_ready});
      fire      = bus.mc_valid && m_ready;
      acc       = bus.wb_valid && !m_stall;
      take_fifo = m_stall || (!bus.wb_valid && mq.size() > 0);
      if (reset) begin
         mq.delete();
         m_age    = 0;
         e_reg_wr = 1'b0;
         e_r_type = 1'b0;
         e_rs2    = '0;
         e_rd     = '0;
         e_busw   = '0;
         acc      = 1'b0;
         fire     = 1'b0;
      end else begin
         if (acc) begin
            dest     = bus.wb_r_type ? bus.wb_rd : bus.wb_rs2;
            e_reg_wr = (dest != 5'd0);
            e_r_type = bus.wb_r_type;
            e_rs2    = bus.wb_rs2;
            e_rd     = bus.wb_rd;
            e_busw   = bus.wb_data;
         end else if (take_fifo) begin
            h        = mq[0];
            e_reg_wr = (h.rd != 5'd0);
            e_r_type = 1'b1;
            e_rs2    = '0;
            e_rd     = h.rd;
            e_busw   = h.data;
         end else begin
            e_reg_wr = 1'b0;
         end
         if (take_fifo) begin
            void'(mq.pop_front());
            m_age = 0;
         end else if (mq.size() > 0) begin
            m_age = (m_age < MW) ? m_age + 1 : MW;
         end
         if (fire && bus.mc_rd != 5'd0) begin
            mq.push_back('{rd: bus.mc_rd, data: bus.mc_data});
         end
         if (mq.size() == 0) m_age = 0;
      end
      last_wb_acc  = acc;
      last_mc_fire = fire;
      @(posedge clk);
      #1;
      check("reg_wr", {31'd0, bus.reg_wr}, {31'd0, e_reg_wr});
      check("r_type", {31'd0, bus.r_type}, {31'd0, e_r_type});
      check("rs2_wb", {27'd0, bus.rs2_wb}, {27'd0, e_rs2});
      check("rd_wb", {27'd0, bus.rd_wb}, {27'd0, e_rd});
      check("busW", bus.busW, e_busw);
   endtask

   initial begin
      reset         = 1'b1;
      bus.wb_valid  = 1'b0;
      bus.wb_r_type = 1'b0;
      bus.wb_rs2    = '0;
      bus.wb_rd     = '0;
      bus.wb_data   = '0;
      bus.mc_valid  = 1'b0;
      bus.mc_rd     = '0;
      bus.mc_data   = '0;
      @(posedge clk);
      #1;
      step();
      check("rst_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
      check("rst_busW", bus.busW, 32'd0);
      check("rst_mc_ready", {31'd0, bus.mc_ready}, 32'd1);
      check("rst_stall", {31'd0, bus.stall_pipe}, 32'd0);
      reset = 1'b0;

      // Pipeline-only write
      bus.wb_valid  = 1'b1;
      bus.wb_r_type = 1'b1;
      bus.wb_rd     = 5'd5;
      bus.wb_data   = 32'h1234;
      step();
      check("pipe_reg_wr", {31'd0, bus.reg_wr}, 32'd1);
      check("pipe_rd_wb", {27'd0, bus.rd_wb}, 32'd5);
      check("pipe_busW", bus.busW, 32'h1234);
      bus.wb_valid = 1'b0;

      // Idle pipeline, one multicycle result
      bus.mc_valid = 1'b1;
      bus.mc_rd    = 5'd7;
      bus.mc_data  = 32'hA;
      step();
      bus.mc_valid = 1'b0;
      step();
      check("mc_reg_wr", {31'd0, bus.reg_wr}, 32'd1);
      check("mc_r_type", {31'd0, bus.r_type}, 32'd1);
      check("mc_rd_wb", {27'd0, bus.rd_wb}, 32'd7);
      check("mc_busW", bus.busW, 32'hA);

      // Starvation: head ages out while the pipeline writes every cycle
      bus.wb_valid  = 1'b1;
      bus.wb_r_type = 1'b1;
      bus.wb_rd     = 5'd3;
      bus.wb_data   = 32'h30;
      bus.mc_valid  = 1'b1;
      bus.mc_rd     = 5'd9;
      bus.mc_data   = 32'h99;
      step();
      bus.mc_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("starve_no_stall", {31'd0, bus.stall_pipe}, 32'd0);
         bus.wb_data = 32'h31 + k;
         step();
      end
      check("starve_stall", {31'd0, bus.stall_pipe}, 32'd1);
      step();
      check("starve_fifo_wr", {31'd0, bus.reg_wr}, 32'd1);
      check("starve_fifo_rd", {27'd0, bus.rd_wb}, 32'd9);
      check("starve_fifo_data", bus.busW, 32'h99);
      step();
      check("starve_held_rd", {27'd0, bus.rd_wb}, 32'd3);
      check("starve_held_data", bus.busW, 32'h34);
      check("starve_held_wr", {31'd0, bus.reg_wr}, 32'd1);

      // Three back-to-back multicycle results against a busy pipeline
      bus.wb_rd    = 5'd1;
      bus.wb_data  = 32'h100;
      bus.mc_valid = 1'b1;
      bus.mc_rd    = 5'd10;
      bus.mc_data  = 32'hA10;
      step();
      bus.mc_rd   = 5'd11;
      bus.mc_data = 32'hA11;
      step();
      bus.mc_rd   = 5'd12;
      bus.mc_data = 32'hA12;
      check("fill_ready_full", {31'd0, bus.mc_ready}, 32'd0);
      got_data.delete();
      got_rd.delete();
      for (int c = 0; c < 60; c++) begin
         step();
         if (bus.reg_wr && bus.r_type && bus.rd_wb >= 5'd10) begin
            got_rd.push_back(bus.rd_wb);
            got_data.push_back(bus.busW);
         end
         if (last_mc_fire) bus.mc_valid = 1'b0;
         if (last_wb_acc) bus.wb_data = bus.wb_data + 1;
         if (!bus.mc_valid && mq.size() == 0) break;
      end
      check("fill_count", got_data.size(), 32'd3);
      for (int j = 0; j < 3; j++) begin
         check("fill_order_data", (j < got_data.size()) ? got_data[j] : 32'hFFFF_FFFF,
               32'hA10 + j);
         check("fill_order_rd", (j < got_rd.size()) ? {27'd0, got_rd[j]} : 32'hFFFF_FFFF,
               32'd10 + j);
      end

      // Zero-register destinations from both sources
      bus.wb_valid  = 1'b1;
      bus.wb_r_type = 1'b1;
      bus.wb_rd     = 5'd0;
      bus.wb_rs2    = 5'd4;
      bus.wb_data   = 32'h55;
      bus.mc_valid  = 1'b1;
      bus.mc_rd     = 5'd0;
      bus.mc_data   = 32'hDEAD;
      step();
      check("zero_reg_wr_a", {31'd0, bus.reg_wr}, 32'd0);
      bus.mc_valid = 1'b0;
      bus.wb_valid = 1'b0;
      step();
      check("zero_reg_wr_b", {31'd0, bus.reg_wr}, 32'd0);
      check("zero_mc_ready", {31'd0, bus.mc_ready}, 32'd1);
      check("zero_stall", {31'd0, bus.stall_pipe}, 32'd0);

      // Reset with two buffered results
      bus.wb_valid  = 1'b1;
      bus.wb_rd     = 5'd2;
      bus.wb_data   = 32'h200;
      bus.mc_valid  = 1'b1;
      bus.mc_rd     = 5'd13;
      bus.mc_data   = 32'hD13;
      step();
      bus.mc_rd   = 5'd14;
      bus.mc_data = 32'hD14;
      step();
      bus.mc_valid = 1'b0;
      check("prerst_full", {31'd0, bus.mc_ready}, 32'd0);
      reset        = 1'b1;
      bus.wb_valid = 1'b0;
      step();
      reset = 1'b0;
      check("midrst_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
      check("midrst_busW", bus.busW, 32'd0);
      check("midrst_rd_wb", {27'd0, bus.rd_wb}, 32'd0);
      check("midrst_mc_ready", {31'd0, bus.mc_ready}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("postrst_no_wr", {31'd0, bus.reg_wr}, 32'd0);
      end

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (!bus.wb_valid || last_wb_acc) begin
            bus.wb_valid  = ($urandom_range(0, 2) != 0);
            bus.wb_r_type = $urandom_range(0, 1);
            bus.wb_rs2    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.wb_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.wb_data   = $urandom;
         end
         bus.mc_valid = $urandom_range(0, 1);
         bus.mc_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         bus.mc_data  = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4, cycles a buffered multicycle result may be bypassed before the pipeline is stalled (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wb_valid  input  1  pipeline writeback stage holds a result to write.
REQ-005 wb_r_type  input  1  destination select of pipeline result: 0 selects wb_rs2, 1 selects wb_rd.
REQ-006 wb_rs2, wb_rd  input  5 each  pipeline destination candidates.
REQ-007 wb_data  input  32  pipeline result.
REQ-008 mc_valid  input  1  multicycle unit offers a result.
REQ-009 mc_ready  output  1  arbiter accepts the multicycle result this cycle.
REQ-010 mc_rd  input  5  multicycle destination register.
REQ-011 mc_data  input  32  multicycle result.
REQ-012 stall_pipe  output  1  pipeline writeback is refused this cycle and must be held.
REQ-013 reg_wr, r_type  output  1 each  register-file write enable and destination select.
REQ-014 rs2_wb, rd_wb  output  5 each  register-file destination candidates.
REQ-015 busW  output  32  register-file write data.

Function
REQ-016 The block SHALL arbitrate the single register-file write port between the pipeline writeback stage and a 2-entry FIFO of multicycle results.
REQ-017 mc_ready SHALL equal (FIFO count < 2); a transfer occurs when mc_valid and mc_ready are both 1 at a clock edge.
REQ-018 A transfer with mc_rd = 0 SHALL be consumed and discarded, not enqueued.
REQ-019 When the FIFO is full, mc_ready SHALL be 0 even if the head is popped in the same cycle.
REQ-020 Pipeline acceptance SHALL be wb_valid AND NOT stall_pipe; an accepted result is written once; a refused result is held upstream unchanged.
REQ-021 stall_pipe SHALL equal (FIFO not empty AND age = MAX_WAIT), a function of registered state only.
REQ-022 Grant per cycle, priority order: FIFO head if stall_pipe; else pipeline if wb_valid; else FIFO head if not empty; else none.
REQ-023 age SHALL clear on reset and on every pop, increment by 1 each cycle the head is present and not granted, and saturate at MAX_WAIT.
REQ-024 An entry pushed into an empty FIFO SHALL start with age 0 and is grantable no earlier than the following cycle.
REQ-025 Write-port outputs SHALL be registered with 1-cycle latency: the grant decided in cycle N appears on reg_wr/r_type/rs2_wb/rd_wb/busW in cycle N+1.
REQ-026 Pipeline grant SHALL drive r_type = wb_r_type, rs2_wb = wb_rs2, rd_wb = wb_rd, busW = wb_data.
REQ-027 FIFO grant SHALL drive r_type = 1, rd_wb = head destination, rs2_wb = 0, busW = head data, and pop the head.
REQ-028 reg_wr SHALL be 1 only for a grant whose selected destination is nonzero; a pipeline write to register 0 is accepted but produces reg_wr = 0.
REQ-029 With no grant, reg_wr SHALL be 0 and the other write-port outputs SHALL hold their previous values.
REQ-030 Simultaneous push and pop on a 1-entry FIFO SHALL leave count 1 and make the new entry head with age 0.
REQ-031 FIFO order SHALL be strict FIFO; no entry is lost or duplicated.

Reset
REQ-032 Reset SHALL empty the FIFO, clear age, and drive reg_wr = 0, r_type = 0, rs2_wb = 0, rd_wb = 0, busW = 0 in the following cycle.
REQ-033 Consequently, mc_ready = 1 and stall_pipe = 0 after reset.
REQ-034 Reset asserted mid-operation SHALL discard buffered results without issuing their writes.

Structure
REQ-035 FIFO depth (2), the MAX_WAIT default and the zero-register index SHALL be constants in the shared package.
REQ-036 The 2-entry FIFO SHALL be one sub-module, wb_fifo2, with push/pop/full/empty/head ports; arbitration, age counter and output registers SHALL reside in reg_wb_arbiter.

Verification
REQ-037 Reset, then pipeline-only writes: wb_valid = 1, wb_r_type = 1, wb_rd = 5, wb_data = 0x1234 -> next cycle reg_wr = 1, rd_wb = 5, busW = 0x1234.
REQ-038 Idle pipeline: mc push (rd = 7, data = 0xA) -> two cycles later reg_wr = 1, r_type = 1, rd_wb = 7, busW = 0xA.
REQ-039 Starvation with MAX_WAIT = 4: one mc entry plus continuous wb_valid -> stall_pipe = 1 exactly 4 cycles after the entry becomes head; FIFO write issued; the held pipeline write issued next cycle.
REQ-040 Fill the FIFO with 3 back-to-back mc_valid while wb_valid = 1 -> mc_ready = 0 on the third; pushed data written in order, none lost.
REQ-041 mc_rd = 0 push and pipeline wb_rd = 0 -> no reg_wr pulses; FIFO count stays 0.
REQ-042 Reset asserted with 2 entries buffered -> no buffered writes emitted; outputs zero; mc_ready = 1.
